// File: rtl/sram_delay_responder_pkg.sv
// Shared types and sizes for the async-SRAM responder used by the pixel-delay buffer.
// The FSM state encoding lives here so the bench can name states directly.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_ADDR,
    S_RD_CAP
  } SramState_t;

endpackage

// File: rtl/sram_delay_responder_dq_pad.sv
// Bidirectional SRAM data pad: drives the DQ pins only while i_oe is set,
// and always returns the pin value on o_din.
module sram_dq_pad #(
  parameter int W = 16
) (
  input  logic         i_oe,
  input  logic [W-1:0] i_dout,
  inout  wire  [W-1:0] io_dq,
  output logic [W-1:0] o_din
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign io_dq[gi] = i_oe ? i_dout[gi] : 1'bz;
  end

  assign o_din = io_dq;

endmodule

// File: rtl/sram_delay_responder.sv
// Turns the delay-buffer initiator's level-style (wen, addr, wdata) request into
// timed read/write cycles on the async SRAM; every pin-facing signal is a flop.
module sram_delay_responder
  import sram_pkg::*;
#(
  parameter int                ADDR_W   = SRAM_ADDR_W,
  parameter int                DATA_W   = SRAM_DATA_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_ready,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  SramState_t        state_q, state_d;
  logic              pend_q, pend_d;
  logic              pend_wen_q, pend_wen_d;
  logic              last_wen_q, last_wen_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              ce_n_q, ce_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] dq_in;
  logic              trigger;

  sram_dq_pad #(.W(DATA_W)) u_dq_pad (
    .i_oe   (dq_oe_q),
    .i_dout (wdata_q),
    .io_dq  (io_sram_dq),
    .o_din  (dq_in)
  );

  // A trigger is a change of the level request; the pending cycle keeps the
  // freshly latched address stable on the pins before any strobe moves.
  assign trigger = (state_q == S_IDLE) && !pend_q &&
                   ({i_wen, i_addr} != {last_wen_q, last_addr_q});

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_wen_d  = pend_wen_q;
    last_wen_d  = last_wen_q;
    last_addr_d = last_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    sram_addr_d = sram_addr_q;
    ce_n_d      = 1'b0;

    if (trigger) begin
      last_wen_d  = i_wen;
      last_addr_d = i_addr;
      if (i_addr > ADDR_MAX) begin
        err_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_wen_d  = i_wen;
        sram_addr_d = i_addr;
        wdata_d     = i_wdata;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = pend_wen_q ? S_WR_SETUP : S_RD_ADDR;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_IDLE;
      S_RD_ADDR:  state_d = S_RD_CAP;
      S_RD_CAP: begin
        rdata_d  = dq_in;
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase

    // Strobes follow the upcoming state so they leave the flops glitch-free.
    we_n_d  = (state_d != S_WR_PULSE);
    oe_n_d  = !((state_d == S_RD_ADDR) || (state_d == S_RD_CAP));
    dq_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
              (state_d == S_WR_HOLD);
    ready_d = (state_d == S_IDLE) && !pend_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      pend_wen_q  <= 1'b0;
      last_wen_q  <= 1'b0;
      last_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_wen_q  <= pend_wen_d;
      last_wen_q  <= last_wen_d;
      last_addr_q <= last_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ce_n_q      <= ce_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_ready     = ready_q;
  assign o_err       = err_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_lb_n = ce_n_q;
  assign o_sram_ub_n = ce_n_q;

endmodule

// File: tb/tb_sram_delay_responder.sv
// Bench for sram_delay_responder: behavioural async SRAM on the pins, read data
// checked through a scoreboard queue filled from a bench-side memory model.
module tb_sram_delay_responder;
  import sram_pkg::*;

  localparam logic [19:0] ADDR_MAX = 20'd6451;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wen   = 1'b0;
  logic [19:0] i_addr  = '0;
  logic [15:0] i_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_rvalid, o_ready, o_err;
  logic [19:0] o_sram_addr;
  wire  [15:0] io_sram_dq;
  logic        o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_mem [int];
  logic [15:0] sb_q [$];
  logic [19:0] served_addr = '0;

  sram_delay_responder #(.ADDR_W(20), .DATA_W(16), .ADDR_MAX(ADDR_MAX)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wen       (i_wen),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_ready     (o_ready),
    .o_err       (o_err),
    .o_sram_addr (o_sram_addr),
    .io_sram_dq  (io_sram_dq),
    .o_sram_we_n (o_sram_we_n),
    .o_sram_oe_n (o_sram_oe_n),
    .o_sram_ce_n (o_sram_ce_n),
    .o_sram_lb_n (o_sram_lb_n),
    .o_sram_ub_n (o_sram_ub_n)
  );

  always #5 i_clk = ~i_clk;

  // Async SRAM: latches on the rising edge of WE_N, drives DQ while OE_N is low.
  logic [15:0] sram_mem [0:8191];
  always @(posedge o_sram_we_n) begin
    if (o_sram_ce_n == 1'b0) sram_mem[o_sram_addr[12:0]] <= io_sram_dq;
  end
  assign io_sram_dq = (o_sram_oe_n == 1'b0 && o_sram_ce_n == 1'b0 && o_sram_we_n == 1'b1)
                      ? sram_mem[o_sram_addr[12:0]] : 16'bz;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes got %b want 11111",
               {o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n});
    end
    checks++;
    if ({o_ready, o_rvalid, o_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags ready/rvalid/err got %b want 000", {o_ready, o_rvalid, o_err});
    end
    checks++;
    if (o_rdata !== 16'h0 || o_sram_addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_data rdata=%h addr=%h want 0/0", o_rdata, o_sram_addr);
    end
    checks++;
    if (dut.dq_oe_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_dq_drive got %b want 0", dut.dq_oe_q);
    end
    i_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (o_sram_we_n !== 1'b1 || o_sram_oe_n !== 1'b1 || o_rvalid !== 1'b0 ||
          o_ready !== 1'b1 || o_sram_ce_n !== 1'b0 || o_sram_lb_n !== 1'b0 ||
          o_sram_ub_n !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold c=%0d we=%b oe=%b rvalid=%b ready=%b ce=%b want 1 1 0 1 0",
                 c, o_sram_we_n, o_sram_oe_n, o_rvalid, o_ready, o_sram_ce_n);
      end
    end
  endtask

  task automatic test_write(input logic [19:0] addr, input logic [15:0] data);
    logic exp_we;
    logic exp_drive;
    i_wen   = 1'b1;
    i_addr  = addr;
    i_wdata = data;
    exp_mem[int'(addr)] = data;
    served_addr = addr;
    tick();
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_ready_k addr=%0d got %b want 0", addr, o_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_we    = (i == 2) ? 1'b0 : 1'b1;
      exp_drive = (i <= 3);
      checks++;
      if (o_sram_we_n !== exp_we || o_sram_oe_n !== 1'b1 || dut.dq_oe_q !== exp_drive) begin
        errors++;
        $display("FAIL write_strobes k+%0d we=%b oe=%b drive=%b want %b 1 %b",
                 i, o_sram_we_n, o_sram_oe_n, dut.dq_oe_q, exp_we, exp_drive);
      end
      if (exp_drive) begin
        checks++;
        if (io_sram_dq !== data || o_sram_addr !== addr) begin
          errors++;
          $display("FAIL write_bus k+%0d dq=%h addr=%0d want %h %0d",
                   i, io_sram_dq, o_sram_addr, data, addr);
        end
      end
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_ready_done got %b want 1", o_ready);
    end
    // A data-only change must not start a cycle.
    i_wdata = ~data;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (o_sram_we_n !== 1'b1 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL wdata_only c=%0d we=%b ready=%b want 1 1", c, o_sram_we_n, o_ready);
      end
    end
  endtask

  task automatic test_read(input logic [19:0] addr);
    int c;
    logic exp_oe;
    logic [15:0] exp_data;
    i_wen  = 1'b0;
    i_addr = addr;
    sb_q.push_back(exp_mem[int'(addr)]);
    served_addr = addr;
    tick();
    c = 0;
    do begin
      tick();
      c++;
      exp_oe = (c <= 2) ? 1'b0 : 1'b1;
      checks++;
      if (o_sram_oe_n !== exp_oe || o_sram_we_n !== 1'b1 || dut.dq_oe_q !== 1'b0) begin
        errors++;
        $display("FAIL read_strobes k+%0d oe=%b we=%b drive=%b want %b 1 0",
                 c, o_sram_oe_n, o_sram_we_n, dut.dq_oe_q, exp_oe);
      end
    end while (!o_rvalid && c < 8);
    checks++;
    if (o_rvalid !== 1'b1 || c != 3) begin
      errors++;
      $display("FAIL read_latency addr=%0d rvalid=%b at k+%0d want 1 at k+3", addr, o_rvalid, c);
    end
    if (sb_q.size() > 0) begin
      exp_data = sb_q.pop_front();
      checks++;
      if (o_rdata !== exp_data) begin
        errors++;
        $display("FAIL read_data addr=%0d got %h want %h", addr, o_rdata, exp_data);
      end
    end
    tick();
    checks++;
    if (o_rvalid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_pulse rvalid=%b ready=%b want 0 1", o_rvalid, o_ready);
    end
  endtask

  task automatic test_err(input logic [19:0] addr);
    i_wen  = 1'b1;
    i_addr = addr;
    tick();
    checks++;
    if (o_err !== 1'b1 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse addr=%0d err=%b ready=%b want 1 1", addr, o_err, o_ready);
    end
    tick();
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_width got %b want 0", o_err);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (o_sram_we_n !== 1'b1 || o_sram_oe_n !== 1'b1 || o_ready !== 1'b1 ||
          o_err !== 1'b0 || o_sram_addr !== served_addr) begin
        errors++;
        $display("FAIL err_quiet c=%0d we=%b oe=%b ready=%b err=%b addr=%0d want 1 1 1 0 %0d",
                 c, o_sram_we_n, o_sram_oe_n, o_ready, o_err, o_sram_addr, served_addr);
      end
    end
  endtask

  task automatic test_back_to_back;
    int we_low;
    i_wen   = 1'b1;
    i_addr  = 20'd7;
    i_wdata = 16'h1111;
    exp_mem[7] = 16'h1111;
    tick();
    i_addr  = 20'd8;
    i_wdata = 16'h8888;
    tick();
    i_addr  = 20'd9;
    i_wdata = 16'h9999;
    exp_mem[9] = 16'h9999;
    we_low = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_sram_we_n === 1'b0) we_low++;
      checks++;
      if (o_sram_addr === 20'd8 || (o_sram_we_n === 1'b0 && o_sram_oe_n === 1'b0)) begin
        errors++;
        $display("FAIL b2b_bus c=%0d addr=%0d we=%b oe=%b (addr 8 or overlap not allowed)",
                 c, o_sram_addr, o_sram_we_n, o_sram_oe_n);
      end
    end
    checks++;
    if (we_low != 2) begin
      errors++;
      $display("FAIL b2b_writes got %0d want 2", we_low);
    end
    checks++;
    if (o_sram_addr !== 20'd9 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final addr=%0d ready=%b want 9 1", o_sram_addr, o_ready);
    end
    served_addr = 20'd9;
  endtask

  task automatic test_reset_mid_write;
    i_wen   = 1'b1;
    i_addr  = 20'd3;
    i_wdata = 16'h5555;
    tick();
    tick();
    tick();
    checks++;
    if (o_sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pulse we=%b want 0", o_sram_we_n);
    end
    #2;
    i_rst_n = 1'b0;
    i_wen   = 1'b0;
    i_addr  = '0;
    #1;
    checks++;
    if (o_sram_we_n !== 1'b1 || dut.dq_oe_q !== 1'b0 || dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL rst_mid_async we=%b drive=%b state=%0d want 1 0 %0d",
               o_sram_we_n, dut.dq_oe_q, dut.state_q, S_IDLE);
    end
    checks++;
    if (o_rdata !== 16'h0 || o_ready !== 1'b0 || o_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs rdata=%h ready=%b rvalid=%b want 0 0 0",
               o_rdata, o_ready, o_rvalid);
    end
    tick();
    i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (o_sram_we_n !== 1'b1 || o_sram_oe_n !== 1'b1 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_no_retry c=%0d we=%b oe=%b ready=%b want 1 1 1",
                 c, o_sram_we_n, o_sram_oe_n, o_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write(20'd5, 16'hABCD);
    test_read(20'd5);
    test_err(20'd6452);
    test_write(ADDR_MAX, 16'h1234);
    test_read(ADDR_MAX);
    test_back_to_back();
    test_read(20'd9);
    test_read(20'd7);
    test_reset_mid_write();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left %0d entries want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
